// File: rtl/pc_image_loader_if.sv
// Handshake bundle between the image loader and its RAM / UART / host peers.
// The master side is the loader; the slave side is the surrounding environment.
interface pc_image_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_q;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_rdy;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              busy;
  logic              done;
  logic [7:0]        result;
  logic              result_valid;
  logic              timeout_err;

  modport master (
    input  start, ram_q, tx_rdy, rx_data, rx_rdy,
    output ram_addr, tx_data, tx_start, busy, done, result, result_valid, timeout_err
  );

  modport slave (
    output start, ram_q, tx_rdy, rx_data, rx_rdy,
    input  ram_addr, tx_data, tx_start, busy, done, result, result_valid, timeout_err
  );
endinterface

// File: rtl/pc_image_loader.sv
// Reads NUM_BYTES*8 image bits from a 1-bit RAM, packs them LSB-first into bytes,
// streams them to a UART transmitter and then waits for one response byte.
module pc_image_loader #(
  parameter int NUM_BYTES    = 98,
  parameter int ADDR_W       = 10,
  parameter int RESP_TIMEOUT = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_image_loader_if.master   bus
);
  localparam int BYTE_W = $clog2(NUM_BYTES + 1);
  localparam int TMO_W  = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, CAPT, TX_WAIT, TX_GO, TX_GUARD, RESP
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              guard_q, guard_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              done_q, done_d;
  logic [7:0]        result_q, result_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;

  logic              start_ok;
  logic              last_byte;
  logic              tmo_hit;
  logic              tx_ack;
  logic [BYTE_W+2:0] addr_full;

  // A start that coincides with the done pulse belongs to the finished run.
  assign start_ok  = bus.start && !done_q;
  assign last_byte = (byte_cnt_q == BYTE_W'(NUM_BYTES - 1));
  assign tmo_hit   = (tmo_q == TMO_W'(RESP_TIMEOUT - 1));
  assign tx_ack    = !guard_q && bus.tx_rdy;
  assign addr_full = {byte_cnt_q, bit_cnt_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = ADDR;
      ADDR:     state_d = CAPT;
      CAPT:     state_d = (bit_cnt_q == 3'd7) ? TX_WAIT : ADDR;
      TX_WAIT:  if (bus.tx_rdy) state_d = TX_GO;
      TX_GO:    state_d = TX_GUARD;
      TX_GUARD: if (tx_ack) state_d = last_byte ? RESP : ADDR;
      RESP:     if (bus.rx_rdy || tmo_hit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.tx_start = (state_q == TX_GO);
    bus.ram_addr = '0;
    if (state_q == ADDR || state_q == CAPT) begin
      bus.ram_addr = ADDR_W'(addr_full);
    end
  end

  assign bus.tx_data      = shreg_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout_err  = terr_q;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    guard_d    = guard_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    result_d   = result_q;
    valid_d    = valid_q;
    terr_d     = terr_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          valid_d    = 1'b0;
          terr_d     = 1'b0;
        end
      end
      CAPT: begin
        shreg_d[bit_cnt_q] = bus.ram_q;
        bit_cnt_d          = bit_cnt_q + 3'd1;
      end
      TX_GO: guard_d = 1'b1;
      TX_GUARD: begin
        guard_d = 1'b0;
        if (tx_ack) begin
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          bit_cnt_d  = '0;
          tmo_d      = '0;
        end
      end
      RESP: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.rx_rdy) begin
          result_d = bus.rx_data;
          valid_d  = 1'b1;
          done_d   = 1'b1;
        end else if (tmo_hit) begin
          terr_d = 1'b1;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      guard_q    <= 1'b0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      guard_q    <= guard_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      terr_q     <= terr_d;
    end
  end
endmodule

// File: tb/tb_pc_image_loader.sv
// Directed bench for pc_image_loader: RAM image, UART tx/rx models and
// hand-computed byte/result expectations across six image runs.
module tb_pc_image_loader;
  localparam int NB     = 98;
  localparam int TMO    = 100;
  localparam int TX_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hold = 1'b0;
  logic model_rdy = 1'b1;
  int   busy_cnt = 0;
  int   tx_cnt = 0;
  int   bad_start = 0;
  int   cyc = 0;
  int   last_start_cyc = 0;
  logic       mem [0:1023];
  logic [7:0] cap [0:1023];

  int n_tests = 0;
  int n_fail = 0;
  int base = 0;
  int bad_base = 0;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [0:5];

  pc_image_loader_if #(.ADDR_W(10)) bus ();

  pc_image_loader #(
    .NUM_BYTES(NB), .ADDR_W(10), .RESP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  assign bus.tx_rdy = model_rdy & ~hold;

  // UART transmitter model: busy for TX_LAT cycles after each launch.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      model_rdy <= 1'b1;
      busy_cnt  <= 0;
    end else if (bus.tx_start) begin
      if (!bus.tx_rdy) bad_start <= bad_start + 1;
      cap[tx_cnt[9:0]] <= bus.tx_data;
      tx_cnt           <= tx_cnt + 1;
      last_start_cyc   <= cyc;
      busy_cnt         <= TX_LAT;
      model_rdy        <= 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_rdy <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic begin_run(input string tag);
    base     = tx_cnt;
    bad_base = bad_start;
    pulse_start();
    check({tag, "_busy_after_start"}, bus.busy, 1);
    check({tag, "_first_addr"}, bus.ram_addr, 0);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    for (int k = 0; k < 6000 && (tx_cnt - base) < n; k++) @(negedge clk);
    check({tag, "_reached_bytes"}, ((tx_cnt - base) >= n), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 500 && !bus.done; k++) @(negedge clk);
    check({tag, "_done_seen"}, bus.done, 1);
  endtask

  task automatic respond(input logic [7:0] val);
    bus.rx_data = val;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic check_image(input string tag);
    int bad;
    logic [7:0] e;
    for (int v = 0; v < 6; v++) begin
      check($sformatf("%s_byte%0d", tag, vecs[v].idx), cap[(base + vecs[v].idx) % 1024], vecs[v].exp);
    end
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < 8; j++) e[j] = mem[8 * i + j];
      if (cap[(base + i) % 1024] !== e) bad++;
    end
    check({tag, "_all_bytes_bad"}, bad, 0);
    check({tag, "_tx_count"}, tx_cnt - base, NB);
    check({tag, "_start_without_rdy"}, bad_start - bad_base, 0);
  endtask

  task automatic finish_ok(input string tag, input logic [7:0] val);
    wait_done(tag);
    check({tag, "_result"}, bus.result, val);
    check({tag, "_result_valid"}, bus.result_valid, 1);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, bus.done, 0);
    check({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    int viol;
    logic [7:0] held;
    logic [7:0] b;

    vecs[0] = '{0,  8'h0D};
    vecs[1] = '{1,  8'h5B};
    vecs[2] = '{20, 8'h4E};
    vecs[3] = '{40, 8'h72};
    vecs[4] = '{50, 8'h68};
    vecs[5] = '{97, 8'h3B};
    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
    mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1;
    for (int i = 1; i < NB; i++) begin
      b = 8'(i) ^ 8'h5A;
      for (int j = 0; j < 8; j++) mem[8 * i + j] = b[j];
    end

    bus.start = 1'b0; bus.rx_rdy = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_result", {bus.result_valid, bus.timeout_err, bus.result}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Run A: normal image, response 0x07, then start coinciding with done.
    begin_run("A");
    wait_bytes("A", NB);
    repeat (20) @(negedge clk);
    respond(8'h07);
    wait_done("A");
    check("A_result", bus.result, 8'h07);
    check("A_result_valid", bus.result_valid, 1);
    check("A_timeout_err", bus.timeout_err, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("A_done_1cyc", bus.done, 0);
    check("A_start_on_done_ignored", bus.busy, 0);
    check_image("A");
    repeat (3) @(negedge clk);

    // Run B: no response; done exactly TMO cycles after RESP entry.
    begin_run("B");
    wait_bytes("B", NB);
    wait_done("B");
    check("B_done_latency", cyc - last_start_cyc, TX_LAT + 1 + TMO);
    check("B_timeout_err", bus.timeout_err, 1);
    check("B_result_valid", bus.result_valid, 0);
    check("B_result_held", bus.result, 8'h07);
    @(negedge clk);
    check("B_busy_end", bus.busy, 0);
    check_image("B");

    // Run C: tx_rdy held low for 500 cycles after byte 49 launches.
    begin_run("C");
    wait_bytes("C", 50);
    hold = 1'b1;
    held = bus.tx_data;
    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.tx_start || bus.tx_data !== held || !bus.busy) viol++;
    end
    hold = 1'b0;
    check("C_stall_violations", viol, 0);
    check("C_stalled_byte49", held, 8'(49) ^ 8'h5A);
    wait_bytes("C", NB);
    repeat (10) @(negedge clk);
    respond(8'h3C);
    finish_ok("C", 8'h3C);
    check_image("C");

    // Run D: start and rx byte injected mid-transfer must both be dropped.
    begin_run("D");
    wait_bytes("D", 20);
    bus.start = 1'b1;
    respond(8'hEE);
    bus.start = 1'b0;
    @(negedge clk);
    check("D_result_unchanged", bus.result, 8'h3C);
    check("D_valid_cleared", bus.result_valid, 0);
    wait_bytes("D", NB);
    repeat (10) @(negedge clk);
    respond(8'h2C);
    finish_ok("D", 8'h2C);
    check_image("D");

    // Run E: reset during byte 40, then a fresh run from address 0.
    base = tx_cnt;
    pulse_start();
    wait_bytes("E0", 40);
    rst_n = 1'b0;
    viol = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_start || bus.busy || bus.done || bus.ram_addr != 0) viol++;
    end
    check("E_reset_outputs", viol, 0);
    rst_n = 1'b1;
    @(negedge clk);
    begin_run("E");
    wait_bytes("E", NB);
    repeat (10) @(negedge clk);
    respond(8'h55);
    finish_ok("E", 8'h55);
    check_image("E");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
